raster_setup: RTL and testbench

RASTER_SETUP -- requirements
Module: raster_setup

---
 rtl/raster_setup.sv | 175 +++++++++++++++++
 tb/tb_raster_setup.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/raster_setup.sv
// Purpose: triangle setup stage. Orders vertices counter-clockwise by determinant sign,
//          drops degenerate (zero-area) triangles and attaches an 8-bit bounding box.
// Latency: 3 cycles from the input handshake to m_setup_tvalid; one triangle every 4 cycles at best.
// Backpressure: s_tri_tready is registered and high only in IDLE; the output record holds until m_setup_tready.
// Ports:
//   aclk, arst                         clock and synchronous active-high reset
//   s_tri_tdata/tvalid/tready          packed triangle {z,y2,x2,y1,x1,y0,x0}, 8 bits per field
//   m_setup_tdata/tvalid/tready        {max_y,min_y,max_x,min_x, ordered triangle}
//   tri_in_count, tri_drop_count       wrapping counts of accepted and dropped triangles
module raster_setup #(
    parameter int TW = 56,
    parameter int CW = 16
) (
    input  logic            aclk,
    input  logic            arst,
    input  logic [TW-1:0]   s_tri_tdata,
    input  logic            s_tri_tvalid,
    output logic            s_tri_tready,
    output logic [TW+31:0]  m_setup_tdata,
    output logic            m_setup_tvalid,
    input  logic            m_setup_tready,
    output logic [CW-1:0]   tri_in_count,
    output logic [CW-1:0]   tri_drop_count
);
    localparam int OW = TW + 32;

    typedef enum logic [1:0] {IDLE, DET, BOX, OUT} state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         tri_q, tri_d;
    logic signed [18:0]    det_q, det_d;
    logic [OW-1:0]         rec_q, rec_d;
    logic                  tready_q, tready_d;
    logic                  tvalid_q, tvalid_d;
    logic [CW-1:0]         in_cnt_q, in_cnt_d;
    logic [CW-1:0]         drop_cnt_q, drop_cnt_d;

    // Field views of the latched triangle
    logic [7:0] x0, y0, x1, y1, x2, y2, z;
    assign x0 = tri_q[7:0];
    assign y0 = tri_q[15:8];
    assign x1 = tri_q[23:16];
    assign y1 = tri_q[31:24];
    assign x2 = tri_q[39:32];
    assign y2 = tri_q[47:40];
    assign z  = tri_q[55:48];

    // Determinant: 9-bit signed edge vectors, 18-bit products, 19-bit result.
    // 19 bits cover the full +/-130050 range, so nothing is truncated.
    logic signed [8:0]  dx1, dy1, dx2, dy2;
    logic signed [17:0] p_a, p_b;
    logic signed [18:0] det_c;

    always_comb begin
        dx1   = $signed({1'b0, x1}) - $signed({1'b0, x0});
        dy1   = $signed({1'b0, y1}) - $signed({1'b0, y0});
        dx2   = $signed({1'b0, x2}) - $signed({1'b0, x0});
        dy2   = $signed({1'b0, y2}) - $signed({1'b0, y0});
        p_a   = 18'(dx1) * 18'(dy2);
        p_b   = 18'(dy1) * 18'(dx2);
        det_c = 19'(p_a) - 19'(p_b);
    end

    // Vertex ordering: a negative determinant means clockwise winding, so swap v1/v2.
    logic [7:0] ox1, oy1, ox2, oy2;
    logic [7:0] min_x, max_x, min_y, max_y;

    function automatic logic [7:0] min3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic [7:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [7:0] max3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic [7:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    always_comb begin
        if (det_q[18]) begin
            ox1 = x2;
            oy1 = y2;
            ox2 = x1;
            oy2 = y1;
        end else begin
            ox1 = x1;
            oy1 = y1;
            ox2 = x2;
            oy2 = y2;
        end
        // Bounding box does not depend on vertex order
        min_x = min3(x0, x1, x2);
        max_x = max3(x0, x1, x2);
        min_y = min3(y0, y1, y2);
        max_y = max3(y0, y1, y2);
    end

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        tri_d      = tri_q;
        det_d      = det_q;
        rec_d      = rec_q;
        tvalid_d   = tvalid_q;
        in_cnt_d   = in_cnt_q;
        drop_cnt_d = drop_cnt_q;

        case (state_q)
            IDLE: begin
                if (s_tri_tvalid && tready_q) begin
                    tri_d    = s_tri_tdata;
                    in_cnt_d = in_cnt_q + CW'(1);
                    state_d  = DET;
                end
            end
            DET: begin
                det_d   = det_c;
                state_d = BOX;
            end
            BOX: begin
                if (det_q == 19'sd0) begin
                    drop_cnt_d = drop_cnt_q + CW'(1);
                    state_d    = IDLE;
                end else begin
                    rec_d    = {max_y, min_y, max_x, min_x, z, oy2, ox2, oy1, ox1, y0, x0};
                    tvalid_d = 1'b1;
                    state_d  = OUT;
                end
            end
            OUT: begin
                if (m_setup_tready) begin
                    tvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                tvalid_d = 1'b0;
            end
        endcase

        // Ready is registered so it follows the state without any input-to-output path
        tready_d = (state_d == IDLE);
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            state_q    <= IDLE;
            tri_q      <= '0;
            det_q      <= '0;
            rec_q      <= '0;
            tready_q   <= 1'b0;
            tvalid_q   <= 1'b0;
            in_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tri_q      <= tri_d;
            det_q      <= det_d;
            rec_q      <= rec_d;
            tready_q   <= tready_d;
            tvalid_q   <= tvalid_d;
            in_cnt_q   <= in_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign s_tri_tready   = tready_q;
    assign m_setup_tvalid = tvalid_q;
    assign m_setup_tdata  = rec_q;
    assign tri_in_count   = in_cnt_q;
    assign tri_drop_count = drop_cnt_q;

endmodule

// File: tb/tb_raster_setup.sv
// Purpose: self-checking bench for raster_setup: directed cases then a random stream vs a reference model.
// Latency: checks 3-cycle accept-to-valid and 4-cycle turnaround.
// Backpressure: exercises long output stalls and random m_setup_tready.
module tb_raster_setup;
    localparam int CW = 16;
    localparam int NTRI = 1000;
    localparam int BUDGET = 30000;

    logic          aclk = 1'b0;
    logic          arst = 1'b1;
    logic [55:0]   s_tri_tdata = '0;
    logic          s_tri_tvalid = 1'b0;
    logic          s_tri_tready;
    logic [87:0]   m_setup_tdata;
    logic          m_setup_tvalid;
    logic          m_setup_tready = 1'b0;
    logic [CW-1:0] tri_in_count;
    logic [CW-1:0] tri_drop_count;

    int total = 0;
    int bad = 0;

    raster_setup #(.TW(56), .CW(CW)) dut (
        .aclk           (aclk),
        .arst           (arst),
        .s_tri_tdata    (s_tri_tdata),
        .s_tri_tvalid   (s_tri_tvalid),
        .s_tri_tready   (s_tri_tready),
        .m_setup_tdata  (m_setup_tdata),
        .m_setup_tvalid (m_setup_tvalid),
        .m_setup_tready (m_setup_tready),
        .tri_in_count   (tri_in_count),
        .tri_drop_count (tri_drop_count)
    );

    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [87:0] obs, input logic [87:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [55:0] mk(input int x0, input int y0, input int x1, input int y1,
                                       input int x2, input int y2, input int z);
        return {8'(z), 8'(y2), 8'(x2), 8'(y1), 8'(x1), 8'(y0), 8'(x0)};
    endfunction

    // Reference model: plain integer geometry on the unpacked vertices
    function automatic int det_of(input logic [55:0] t);
        int x[3];
        int y[3];
        for (int i = 0; i < 3; i++) begin
            x[i] = int'(t[16*i +: 8]);
            y[i] = int'(t[16*i+8 +: 8]);
        end
        return (x[1] - x[0]) * (y[2] - y[0]) - (y[1] - y[0]) * (x[2] - x[0]);
    endfunction

    function automatic logic [87:0] rec_of(input logic [55:0] t);
        int x[3];
        int y[3];
        int tmp;
        int mnx, mxx, mny, mxy;
        for (int i = 0; i < 3; i++) begin
            x[i] = int'(t[16*i +: 8]);
            y[i] = int'(t[16*i+8 +: 8]);
        end
        if (det_of(t) < 0) begin
            tmp = x[1]; x[1] = x[2]; x[2] = tmp;
            tmp = y[1]; y[1] = y[2]; y[2] = tmp;
        end
        mnx = 255; mxx = 0; mny = 255; mxy = 0;
        for (int i = 0; i < 3; i++) begin
            if (x[i] < mnx) mnx = x[i];
            if (x[i] > mxx) mxx = x[i];
            if (y[i] < mny) mny = y[i];
            if (y[i] > mxy) mxy = y[i];
        end
        return {8'(mxy), 8'(mny), 8'(mxx), 8'(mnx), t[55:48],
                8'(y[2]), 8'(x[2]), 8'(y[1]), 8'(x[1]), 8'(y[0]), 8'(x[0])};
    endfunction

    // Coordinates biased toward the 0/255 corners
    function automatic int rc();
        case ($urandom_range(3))
            0: return 0;
            1: return 255;
            default: return int'($urandom_range(255));
        endcase
    endfunction

    function automatic logic [55:0] gen();
        logic [55:0] t;
        t = mk(rc(), rc(), rc(), rc(), rc(), rc(), int'($urandom_range(255)));
        // Occasionally force a degenerate triangle (repeated vertex)
        if ($urandom_range(5) == 0) t[47:32] = t[15:0];
        return t;
    endfunction

    initial begin
        logic [55:0] t;
        logic [87:0] exp;
        logic [87:0] q[$];
        logic        in_hs, out_hs;
        int          sent, drops, beats, cyc;

        // ---------------- reset state ----------------
        arst = 1'b1;
        step();
        step();
        chk("rst_tready", 88'(s_tri_tready), 88'(0));
        chk("rst_tvalid", 88'(m_setup_tvalid), 88'(0));
        chk("rst_tdata", m_setup_tdata, 88'(0));
        chk("rst_in_cnt", 88'(tri_in_count), 88'(0));
        chk("rst_drop_cnt", 88'(tri_drop_count), 88'(0));
        arst = 1'b0;
        step();
        chk("rel_tready", 88'(s_tri_tready), 88'(1));

        // ---------------- CCW triangle passes unchanged ----------------
        m_setup_tready = 1'b1;
        s_tri_tdata = mk(0, 0, 10, 0, 0, 10, 5);
        s_tri_tvalid = 1'b1;
        step();
        s_tri_tvalid = 1'b0;
        chk("ccw_busy_tready", 88'(s_tri_tready), 88'(0));
        chk("ccw_in_cnt", 88'(tri_in_count), 88'(1));
        step();
        chk("ccw_early_valid", 88'(m_setup_tvalid), 88'(0));
        step();
        chk("ccw_valid_lat3", 88'(m_setup_tvalid), 88'(1));
        chk("ccw_data", m_setup_tdata, {8'd10, 8'd0, 8'd10, 8'd0, mk(0, 0, 10, 0, 0, 10, 5)});
        step();
        chk("ccw_valid_drop", 88'(m_setup_tvalid), 88'(0));
        chk("ccw_tready_back", 88'(s_tri_tready), 88'(1));

        // ---------------- CW triangle gets v1/v2 swapped ----------------
        s_tri_tdata = mk(0, 0, 0, 10, 10, 0, 7);
        s_tri_tvalid = 1'b1;
        step();
        s_tri_tvalid = 1'b0;
        step();
        step();
        chk("cw_valid", 88'(m_setup_tvalid), 88'(1));
        chk("cw_data", m_setup_tdata, {8'd10, 8'd0, 8'd10, 8'd0, mk(0, 0, 10, 0, 0, 10, 7)});
        step();

        // ---------------- collinear triangle dropped ----------------
        s_tri_tdata = mk(0, 0, 5, 5, 10, 10, 1);
        s_tri_tvalid = 1'b1;
        step();
        s_tri_tvalid = 1'b0;
        step();
        chk("drop_mid_valid", 88'(m_setup_tvalid), 88'(0));
        step();
        chk("drop_valid", 88'(m_setup_tvalid), 88'(0));
        chk("drop_tready", 88'(s_tri_tready), 88'(1));
        chk("drop_cnt", 88'(tri_drop_count), 88'(1));
        chk("drop_in_cnt", 88'(tri_in_count), 88'(3));

        // ---------------- corner triangle under long stall ----------------
        m_setup_tready = 1'b0;
        s_tri_tdata = mk(255, 0, 0, 255, 255, 255, 9);
        s_tri_tvalid = 1'b1;
        step();
        s_tri_tvalid = 1'b0;
        step();
        step();
        exp = {8'd255, 8'd0, 8'd255, 8'd0, mk(255, 0, 255, 255, 0, 255, 9)};
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 88'(m_setup_tvalid), 88'(1));
            chk("stall_data", m_setup_tdata, exp);
            chk("stall_tready", 88'(s_tri_tready), 88'(0));
            step();
        end
        m_setup_tready = 1'b1;
        chk("stall_last_data", m_setup_tdata, exp);
        step();
        m_setup_tready = 1'b0;
        chk("stall_single_beat", 88'(m_setup_tvalid), 88'(0));
        chk("stall_tready_back", 88'(s_tri_tready), 88'(1));

        // ---------------- reset while in OUT ----------------
        s_tri_tdata = mk(3, 4, 50, 6, 7, 80, 2);
        s_tri_tvalid = 1'b1;
        step();
        s_tri_tvalid = 1'b0;
        step();
        step();
        chk("pre_rst_valid", 88'(m_setup_tvalid), 88'(1));
        arst = 1'b1;
        step();
        arst = 1'b0;
        chk("mid_rst_valid", 88'(m_setup_tvalid), 88'(0));
        chk("mid_rst_in_cnt", 88'(tri_in_count), 88'(0));
        chk("mid_rst_drop_cnt", 88'(tri_drop_count), 88'(0));
        chk("mid_rst_tready", 88'(s_tri_tready), 88'(0));
        step();
        chk("post_rst_tready", 88'(s_tri_tready), 88'(1));
        m_setup_tready = 1'b1;
        s_tri_tdata = mk(0, 0, 10, 0, 0, 10, 5);
        s_tri_tvalid = 1'b1;
        step();
        s_tri_tvalid = 1'b0;
        step();
        step();
        chk("post_rst_valid", 88'(m_setup_tvalid), 88'(1));
        chk("post_rst_data", m_setup_tdata, {8'd10, 8'd0, 8'd10, 8'd0, mk(0, 0, 10, 0, 0, 10, 5)});
        chk("post_rst_in_cnt", 88'(tri_in_count), 88'(1));
        step();

        // ---------------- random back-to-back stream ----------------
        arst = 1'b1;
        step();
        arst = 1'b0;
        step();
        sent = 0;
        drops = 0;
        beats = 0;
        cyc = 0;
        t = gen();
        s_tri_tdata = t;
        s_tri_tvalid = 1'b1;
        m_setup_tready = 1'($urandom_range(1));
        while (!(sent == NTRI && q.size() == 0 && s_tri_tready === 1'b1) && cyc < BUDGET) begin
            in_hs  = s_tri_tvalid & s_tri_tready;
            out_hs = m_setup_tvalid & m_setup_tready;
            if (in_hs === 1'b1) begin
                if (det_of(t) == 0) drops++;
                else q.push_back(rec_of(t));
                sent++;
            end
            if (out_hs === 1'b1) begin
                beats++;
                if (q.size() > 0) exp = q.pop_front();
                else exp = 'x;
                chk("stream_data", m_setup_tdata, exp);
            end
            step();
            cyc++;
            if (in_hs === 1'b1) begin
                if (sent < NTRI) begin
                    t = gen();
                    s_tri_tdata = t;
                end else begin
                    s_tri_tvalid = 1'b0;
                end
            end
            m_setup_tready = 1'($urandom_range(1));
        end
        chk("stream_in_budget", 88'(cyc < BUDGET), 88'(1));
        chk("stream_beats", 88'(beats), 88'(NTRI - drops));
        chk("stream_in_cnt", 88'(tri_in_count), 88'(NTRI));
        chk("stream_drop_cnt", 88'(tri_drop_count), 88'(drops));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
